reg_demux: RTL and testbench

Registered demultiplexer, the counterpart of the 2:1 `Mux` primitive: one write stream is steered by `sel` into one of `N` independent hold registers. Each slot carries a valid flag, and the consumer of that slot clears it with a per-slot acknowledge. It sits in the core primitive library. Generated pipelines use it wherever a single producer feeds several consumers that drain at different times.

---
 rtl/reg_demux.sv | 109 ++++++++++
 tb/tb_reg_demux.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_demux.sv
// ---------------------------------------------------------------------------
// reg_demux
//
// Registered demultiplexer. One write stream is steered by sel into one of N
// independent hold registers (slots). Each slot has a valid flag that its
// consumer clears with a per-slot acknowledge. Every output is registered.
//
// Ports:
//   clk       in   1          clock, rising edge
//   reset     in   1          synchronous, active-high reset
//   write_en  in   1          write request this cycle
//   sel       in   SEL_W      target slot of the write
//   in        in   WIDTH      write data
//   ack       in   N          per-slot consume strobe (bit i clears slot i)
//   out       out  N*WIDTH    slot data, slot i at [i*WIDTH +: WIDTH]
//   valid     out  N          per-slot valid flag
//   count     out  clog2(N+1) popcount of valid
//   drop      out  1          pulse: a write overwrote unconsumed data
//   err       out  1          pulse: a write targeted sel >= N
// ---------------------------------------------------------------------------
module reg_demux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_en,
    input  logic [SEL_W-1:0]       sel,
    input  logic [WIDTH-1:0]       in,
    input  logic [N-1:0]           ack,
    output logic [N*WIDTH-1:0]     out,
    output logic [N-1:0]           valid,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   drop,
    output logic                   err
);

    localparam int CNT_W = $clog2(N+1);

    logic [WIDTH-1:0] data_q [N];
    logic [WIDTH-1:0] data_d [N];
    logic [N-1:0]     valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic             inRange;

    // Next-state for all slots. Acks clear valid first; a write to the same
    // slot then sets it again, so the write wins. The range check is done by
    // matching sel against every legal index, so a select that matches none
    // of them is the out-of-range case and touches no slot.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~ack;
        drop_d  = 1'b0;
        inRange = 1'b0;
        count_d = '0;
        for (int i = 0; i < N; i++) begin
            if (write_en && (sel == SEL_W'(i))) begin
                inRange   = 1'b1;
                data_d[i] = in;
                // Overwrite is only a loss if the consumer did not take the
                // old value in this same cycle.
                if (valid_q[i] && !ack[i]) begin
                    drop_d = 1'b1;
                end
                valid_d[i] = 1'b1;
            end
        end
        err_d = write_en && !inRange;
        // Count is derived from the next valid vector so it is registered on
        // the same edge and can never lag behind valid.
        for (int i = 0; i < N; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    // State registers; reset discards everything, including a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_out
        assign out[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign valid = valid_q;
    assign count = count_q;
    assign drop  = drop_q;
    assign err   = err_q;

endmodule

// File: tb/tb_reg_demux.sv
// ---------------------------------------------------------------------------
// tb_reg_demux
//
// Drives a power-of-two instance (N=4) and a non-power-of-two instance (N=3)
// with the same directed vectors. A behavioural slot model tracks both and is
// compared against every output on each falling edge; literal expectations
// at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_reg_demux;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              writeEn;
    logic [1:0]        sel;
    logic [WIDTH-1:0]  dataIn;
    logic [3:0]        ack;

    logic [4*WIDTH-1:0] out4;
    logic [3:0]         valid4;
    logic [2:0]         count4;
    logic               drop4, err4;

    logic [3*WIDTH-1:0] out3;
    logic [2:0]         valid3;
    logic [1:0]         count3;
    logic               drop3, err3;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Model state, index 0 = N=4 instance, index 1 = N=3 instance
    logic [WIDTH-1:0] mData  [2][4];
    logic [3:0]       mValid [2];
    logic             mDrop  [2];
    logic             mErr   [2];

    always #5 clk = ~clk;

    reg_demux #(.WIDTH(WIDTH), .N(4)) dut4 (
        .clk(clk), .reset(reset), .write_en(writeEn), .sel(sel), .in(dataIn),
        .ack(ack), .out(out4), .valid(valid4), .count(count4),
        .drop(drop4), .err(err4)
    );

    reg_demux #(.WIDTH(WIDTH), .N(3)) dut3 (
        .clk(clk), .reset(reset), .write_en(writeEn), .sel(sel), .in(dataIn),
        .ack(ack[2:0]), .out(out3), .valid(valid3), .count(count3),
        .drop(drop3), .err(err3)
    );

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) mData[k][i] = '0;
            mValid[k] = '0;
            mDrop[k]  = 1'b0;
            mErr[k]   = 1'b0;
        end
    end

    // Behavioural model: applies the slot rules to the inputs seen at each
    // rising edge (inputs only change on falling edges).
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int n;
            logic [3:0] nextValid;
            n = (k == 0) ? 4 : 3;
            if (reset) begin
                for (int i = 0; i < 4; i++) mData[k][i] = '0;
                mValid[k] = '0;
                mDrop[k]  = 1'b0;
                mErr[k]   = 1'b0;
            end else begin
                nextValid = mValid[k];
                mDrop[k]  = 1'b0;
                mErr[k]   = 1'b0;
                for (int i = 0; i < n; i++) begin
                    if (ack[i]) nextValid[i] = 1'b0;
                end
                if (writeEn) begin
                    if (int'(sel) < n) begin
                        mDrop[k] = mValid[k][sel] && !ack[sel];
                        mData[k][sel] = dataIn;
                        nextValid[sel] = 1'b1;
                    end else begin
                        mErr[k] = 1'b1;
                    end
                end
                mValid[k] = nextValid;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs of both instances.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [4*WIDTH-1:0] exp4;
            logic [3*WIDTH-1:0] exp3;
            for (int i = 0; i < 4; i++) exp4[i*WIDTH +: WIDTH] = mData[0][i];
            for (int i = 0; i < 3; i++) exp3[i*WIDTH +: WIDTH] = mData[1][i];
            checkOutput("model out4",   128'(out4),   128'(exp4));
            checkOutput("model valid4", 128'(valid4), 128'(mValid[0]));
            checkOutput("model count4", 128'(count4), 128'($countones(mValid[0])));
            checkOutput("model drop4",  128'(drop4),  128'(mDrop[0]));
            checkOutput("model err4",   128'(err4),   128'(mErr[0]));
            checkOutput("model out3",   128'(out3),   128'(exp3));
            checkOutput("model valid3", 128'(valid3), 128'(mValid[1][2:0]));
            checkOutput("model count3", 128'(count3), 128'($countones(mValid[1][2:0])));
            checkOutput("model drop3",  128'(drop3),  128'(mDrop[1]));
            checkOutput("model err3",   128'(err3),   128'(mErr[1]));
        end
    end

    // Drive one cycle of inputs just after a falling edge and return at the
    // next falling edge, when the registered result is visible.
    task automatic applyStimulus(input logic rst, input logic we,
                                 input logic [1:0] s, input logic [31:0] d,
                                 input logic [3:0] a);
        reset   = rst;
        writeEn = we;
        sel     = s;
        dataIn  = d;
        ack     = a;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; writeEn = 1'b0; sel = '0; dataIn = '0; ack = '0;
        @(negedge clk);

        // Reset for two cycles while a write is requested
        applyStimulus(1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 4'b0000);
        checkEn = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'd0, 32'hDEADBEEF, 4'b0000);
        checkOutput("reset out4",   128'(out4),   128'h0);
        checkOutput("reset valid4", 128'(valid4), 128'h0);
        checkOutput("reset count4", 128'(count4), 128'h0);
        checkOutput("reset flags4", 128'({drop4, err4}), 128'h0);

        // Fan-out to all four slots
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h11, 4'b0000);
        checkOutput("fanout valid 1", 128'(valid4), 128'b0001);
        checkOutput("fanout count 1", 128'(count4), 128'd1);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'h22, 4'b0000);
        checkOutput("fanout valid 2", 128'(valid4), 128'b0011);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'h33, 4'b0000);
        checkOutput("fanout valid 3", 128'(valid4), 128'b0111);
        checkOutput("fanout count 3", 128'(count4), 128'd3);
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h44, 4'b0000);
        checkOutput("fanout valid 4", 128'(valid4), 128'b1111);
        checkOutput("fanout count 4", 128'(count4), 128'd4);
        checkOutput("fanout out4",    128'(out4),   128'h00000044_00000033_00000022_00000011);
        checkOutput("sel3 err on N=3", 128'(err3),  128'd1);

        // Ack slots 0 and 2
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0101);
        checkOutput("ack valid4", 128'(valid4), 128'b1010);
        checkOutput("ack count4", 128'(count4), 128'd2);
        checkOutput("ack slot0 data kept", 128'(out4[31:0]), 128'h11);

        // Overwrite: refill slot 2, then overwrite without and with ack
        applyStimulus(1'b0, 1'b1, 2'd2, 32'h33, 4'b0000);
        checkOutput("refill no drop", 128'(drop4), 128'd0);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'h99, 4'b0000);
        checkOutput("overwrite data", 128'(out4[95:64]), 128'h99);
        checkOutput("overwrite drop", 128'(drop4), 128'd1);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'hAA, 4'b0100);
        checkOutput("write+ack drop", 128'(drop4), 128'd0);
        checkOutput("write+ack valid", 128'(valid4), 128'b1110);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'hBB, 4'b0000);
        applyStimulus(1'b0, 1'b1, 2'd2, 32'hCC, 4'b0000);
        checkOutput("back-to-back drop", 128'(drop4), 128'd1);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checkOutput("idle drop low", 128'(drop4), 128'd0);

        // Out of range on N=3, with a same-cycle ack of slot 0
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h77, 4'b0000);
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h55, 4'b0001);
        checkOutput("oor err3",    128'(err3),   128'd1);
        checkOutput("oor valid3",  128'(valid3), 128'b110);
        checkOutput("oor out3",    128'(out3),   128'h000000CC_00000022_00000077);
        applyStimulus(1'b0, 1'b1, 2'd3, 32'h66, 4'b0000);
        checkOutput("oor err3 again", 128'(err3), 128'd1);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checkOutput("oor err3 low", 128'(err3), 128'd0);

        // Reset mid-stream: leave slots 1 and 3 valid, then reset with a write
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b0101);
        checkOutput("pre-reset valid4", 128'(valid4), 128'b1010);
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h12, 4'b0000);
        checkOutput("midreset valid4", 128'(valid4), 128'h0);
        checkOutput("midreset drop4",  128'(drop4),  128'h0);
        checkOutput("midreset out4",   128'(out4),   128'h0);
        applyStimulus(1'b0, 1'b1, 2'd1, 32'h34, 4'b0000);
        checkOutput("post-reset valid4", 128'(valid4), 128'b0010);
        checkOutput("post-reset count4", 128'(count4), 128'd1);
        checkOutput("post-reset out4",   128'(out4),   128'h00000000_00000000_00000034_00000000);

        // A few mixed cycles: write plus acks to other slots
        applyStimulus(1'b0, 1'b1, 2'd3, 32'hA5A5A5A5, 4'b0010);
        checkOutput("mixed valid4", 128'(valid4), 128'b1000);
        applyStimulus(1'b0, 1'b1, 2'd0, 32'h5A5A5A5A, 4'b0001);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        checkOutput("ack all count4", 128'(count4), 128'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
